// File: rtl/jk_pkg.sv
// Shared types for the JK bank arbiter: command encoding and cell update.
// jk_next() returns the next value of one JK cell.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  function automatic logic jk_next(
    input jk_cmd_t c,
    input logic    q
  );
    logic n;
    n = q;
    unique case (c)
      JK_HOLD: n = q;
      JK_CLR:  n = 1'b0;
      JK_SET:  n = 1'b1;
      JK_TGL:  n = ~q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; scans from ptr upward with wrap.
// Ports: req (N requests), ptr (start index) -> gnt (one-hot), gnt_id.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_id
);

  always_comb begin
    logic found;
    int   j;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gnt_id = PW'(j);
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Bank of NBITS JK cells shared by NREQ requesters, one grant per clock.
// Ports: clk, reset, req_valid/cmd/idx in; req_ready, q, last_*, idx_err, acc_cnt out.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_cmd,
  input  logic [IDXW*NREQ-1:0]    req_idx,
  output logic [NREQ-1:0]         req_ready,
  output logic [NBITS-1:0]        q,
  output logic [$clog2(NREQ)-1:0] last_id,
  output logic                    last_valid,
  output logic                    idx_err,
  output logic [CNTW-1:0]         acc_cnt
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    ptr;
  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    g;
  logic             accept;
  jk_cmd_t          sel_cmd;
  logic [IDXW-1:0]  sel_idx;
  logic             in_range;
  logic [NBITS-1:0] q_n;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (g)
  );

  // Grants are suppressed during reset so pending work re-arbitrates after.
  assign req_ready = reset ? '0 : gnt;
  assign accept    = |req_ready;

  assign sel_cmd  = jk_cmd_t'(req_cmd[2*g +: 2]);
  assign sel_idx  = req_idx[IDXW*g +: IDXW];
  assign in_range = int'(sel_idx) < NBITS;

  // Out-of-range indices match no cell, so q is left untouched.
  always_comb begin
    q_n = q;
    for (int i = 0; i < NBITS; i++) begin
      if (accept && int'(sel_idx) == i)
        q_n[i] = jk_next(sel_cmd, q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= '0;
      ptr        <= '0;
      last_id    <= '0;
      last_valid <= 1'b0;
      idx_err    <= 1'b0;
      acc_cnt    <= '0;
    end else begin
      q          <= q_n;
      last_valid <= accept;
      if (accept) begin
        ptr     <= (int'(g) == NREQ-1) ? '0 : g + PW'(1);
        last_id <= g;
        acc_cnt <= acc_cnt + CNTW'(1);
        if (!in_range)
          idx_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (NREQ=4, NBITS=6).
// Hand-computed expectations, one check task, one summary line.
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int IDXW  = 3;
  localparam int CNTW  = 16;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_cmd;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic [NBITS-1:0]     q;
  logic [1:0]           last_id;
  logic                 last_valid;
  logic                 idx_err;
  logic [CNTW-1:0]      acc_cnt;

  int checks = 0;
  int errors = 0;

  jk_bank_arbiter #(
    .NREQ  (NREQ),
    .NBITS (NBITS),
    .IDXW  (IDXW),
    .CNTW  (CNTW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .q          (q),
    .last_id    (last_id),
    .last_valid (last_valid),
    .idx_err    (idx_err),
    .acc_cnt    (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [1:0] c,
                         input logic [2:0] ix);
    req_valid[i]          = v;
    req_cmd[2*i +: 2]     = c;
    req_idx[IDXW*i +: 3]  = ix;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    req_cmd   = '0;
    req_idx   = '0;

    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_cnt", 32'(acc_cnt), 32'h0);
    end
    chk("rst_lv", 32'(last_valid), 32'h0);
    chk("rst_err", 32'(idx_err), 32'h0);

    req_valid = '0;
    reset     = 1'b0;

    set_req(0, 1'b1, 2'b10, 3'd3);
    #1;
    chk("set_ready", 32'(req_ready), 32'h1);
    tick();
    chk("set_q", 32'(q), 32'h08);
    chk("set_lv", 32'(last_valid), 32'h1);
    chk("set_lid", 32'(last_id), 32'h0);
    set_req(0, 1'b1, 2'b11, 3'd3);
    tick();
    chk("tgl_q", 32'(q), 32'h00);
    set_req(0, 1'b1, 2'b01, 3'd3);
    tick();
    chk("clr_q", 32'(q), 32'h00);
    chk("sct_cnt", 32'(acc_cnt), 32'd3);
    set_req(0, 1'b0, 2'b00, 3'd0);
    tick();
    chk("idle_lv", 32'(last_valid), 32'h0);
    chk("idle_cnt", 32'(acc_cnt), 32'd3);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b00, 3'd1);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), 32'(req_ready),
          32'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr_lid%0d", k), 32'(last_id), 32'(k % 4));
    end
    req_valid = '0;
    chk("rr_cnt", 32'(acc_cnt), 32'd8);
    chk("rr_q", 32'(q), 32'h0);

    set_req(1, 1'b1, 2'b11, 3'd0);
    set_req(2, 1'b1, 2'b11, 3'd0);
    #1;
    chk("sc_gnt1", 32'(req_ready), 32'h2);
    tick();
    chk("sc_q1", 32'(q), 32'h1);
    chk("sc_lid1", 32'(last_id), 32'h1);
    set_req(1, 1'b0, 2'b00, 3'd0);
    #1;
    chk("sc_gnt2", 32'(req_ready), 32'h4);
    tick();
    chk("sc_q2", 32'(q), 32'h0);
    chk("sc_lid2", 32'(last_id), 32'h2);
    set_req(2, 1'b0, 2'b00, 3'd0);

    set_req(0, 1'b1, 2'b10, 3'd7);
    #1;
    chk("oor_gnt", 32'(req_ready), 32'h1);
    tick();
    chk("oor_q", 32'(q), 32'h0);
    chk("oor_err", 32'(idx_err), 32'h1);
    chk("oor_cnt", 32'(acc_cnt), 32'd11);
    set_req(0, 1'b0, 2'b00, 3'd0);
    tick();
    tick();
    chk("oor_sticky", 32'(idx_err), 32'h1);

    set_req(1, 1'b1, 2'b10, 3'd5);
    tick();
    chk("mid_q", 32'(q), 32'h20);
    set_req(1, 1'b0, 2'b00, 3'd0);
    set_req(2, 1'b1, 2'b10, 3'd2);
    set_req(0, 1'b1, 2'b10, 3'd1);
    reset = 1'b1;
    #1;
    chk("mid_rdy", 32'(req_ready), 32'h0);
    tick();
    chk("mid_rq", 32'(q), 32'h0);
    chk("mid_rcnt", 32'(acc_cnt), 32'h0);
    chk("mid_rerr", 32'(idx_err), 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_g0", 32'(req_ready), 32'h1);
    tick();
    chk("mid_q0", 32'(q), 32'h02);
    set_req(0, 1'b0, 2'b00, 3'd0);
    #1;
    chk("mid_g2", 32'(req_ready), 32'h4);
    tick();
    chk("mid_q2", 32'(q), 32'h06);
    chk("mid_lid", 32'(last_id), 32'h2);
    chk("mid_cnt", 32'(acc_cnt), 32'd2);
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
